// File: rtl/jam_cost_sched_if.sv
// Permutation handshake between the permutation generator (master) and the
// cost scheduler (slave).
interface jam_cost_sched_if;
  logic        perm_valid;
  logic        perm_ready;
  logic [23:0] perm_data;
  logic        perm_last;

  modport master (output perm_valid, perm_data, perm_last, input perm_ready);
  modport slave  (input perm_valid, perm_data, perm_last, output perm_ready);
endinterface

// File: rtl/jam_cost_sched.sv
// Job-assignment cost sequencer: walks each accepted permutation through the
// cost ROM, tracks the minimum total and how many permutations reach it.
module jam_cost_sched #(
  parameter int PRUNE_EN = 1,
  parameter int MIN_INIT = 1023
) (
  input  logic                   CLK,
  input  logic                   RST,
  jam_cost_sched_if.slave        perm,
  output logic [2:0]             W,
  output logic [2:0]             J,
  input  logic [6:0]             Cost,
  output logic [9:0]             MinCost,
  output logic [3:0]             MatchCount,
  output logic                   Valid
);
  typedef enum logic [1:0] {IDLE, EVAL, CMP, DONE} state_t;

  localparam logic [9:0] MIN_INIT_V = 10'(MIN_INIT);
  localparam bit         PRUNE_ON   = (PRUNE_EN != 0);

  state_t      state;
  logic [23:0] permR;
  logic        lastR;
  logic [9:0]  acc;
  logic [9:0]  accNext;
  logic [2:0]  widx;
  logic        permReady;

  function automatic logic [2:0] jobOf(logic [23:0] p, logic [2:0] i);
    return p[5'(i) * 5'd3 +: 3];
  endfunction

  function automatic logic [3:0] satInc(logic [3:0] v);
    return (v == 4'd15) ? v : v + 4'd1;
  endfunction

  // 8 x 127 = 1016 fits in 10 bits, so the running sum never wraps.
  assign accNext         = acc + 10'(Cost);
  assign W               = widx;
  assign perm.perm_ready = permReady;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      permReady  <= 1'b1;
      widx       <= 3'd0;
      J          <= 3'd0;
      acc        <= 10'd0;
      lastR      <= 1'b0;
      MinCost    <= MIN_INIT_V;
      MatchCount <= 4'd0;
      Valid      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (perm.perm_valid && permReady) begin
            permR     <= perm.perm_data;
            lastR     <= perm.perm_last;
            acc       <= 10'd0;
            widx      <= 3'd0;
            J         <= jobOf(perm.perm_data, 3'd0);
            permReady <= 1'b0;
            state     <= EVAL;
          end
        end
        EVAL: begin
          acc <= accNext;
          // Strictly-greater test keeps ties alive so they are always counted.
          if (PRUNE_ON && (accNext > MinCost)) begin
            widx <= 3'd0;
            J    <= 3'd0;
            if (lastR) begin
              state <= DONE;
              Valid <= 1'b1;
            end else begin
              state     <= IDLE;
              permReady <= 1'b1;
            end
          end else if (widx == 3'd7) begin
            widx  <= 3'd0;
            J     <= 3'd0;
            state <= CMP;
          end else begin
            widx <= widx + 3'd1;
            J    <= jobOf(permR, widx + 3'd1);
          end
        end
        CMP: begin
          if (acc < MinCost) begin
            MinCost    <= acc;
            MatchCount <= 4'd1;
          end else if (acc == MinCost) begin
            MatchCount <= satInc(MatchCount);
          end
          if (lastR) begin
            state <= DONE;
            Valid <= 1'b1;
          end else begin
            state     <= IDLE;
            permReady <= 1'b1;
          end
        end
        DONE: begin
          state <= DONE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_jam_cost_sched.sv
// Randomized bench: two schedulers (pruning on/off) run the same permutation
// lists against a shared cost table and a behavioural model of the search.
module tb_jam_cost_sched;
  logic CLK;
  logic RST;

  logic [6:0]  costTab [8][8];
  logic [23:0] sPerm [32];
  bit          sLast [32];
  int          sN;
  int          abortIdx;
  bit          doneFlag [2];
  event        goEv;
  event        doneEv;

  int nVec;
  int nErr;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic checkVal(string tag, int obs, int exp);
    nVec++;
    if (obs !== exp) begin
      nErr++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  function automatic int jobOf(logic [23:0] p, int i);
    return int'((p >> (3 * i)) & 24'd7);
  endfunction

  function automatic logic [23:0] randPerm();
    int a [8];
    int j;
    int t;
    logic [23:0] p;
    for (int i = 0; i < 8; i++) a[i] = i;
    for (int i = 7; i > 0; i--) begin
      j = int'($urandom_range(0, i));
      t = a[i]; a[i] = a[j]; a[j] = t;
    end
    p = '0;
    for (int i = 0; i < 8; i++) p[3*i +: 3] = 3'(a[i]);
    return p;
  endfunction

  function automatic logic [23:0] rotPerm(int r);
    logic [23:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) p[3*i +: 3] = 3'((i + r) % 8);
    return p;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : lane
    jam_cost_sched_if pif ();
    logic [2:0] W;
    logic [2:0] J;
    logic [6:0] Cost;
    logic [9:0] MinCost;
    logic [3:0] MatchCount;
    logic       Valid;

    assign Cost = costTab[W][J];

    jam_cost_sched #(.PRUNE_EN(g == 0 ? 1 : 0), .MIN_INIT(1023)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .perm       (pif),
      .W          (W),
      .J          (J),
      .Cost       (Cost),
      .MinCost    (MinCost),
      .MatchCount (MatchCount),
      .Valid      (Valid)
    );

    initial begin : engine
      int idx, guard, mMin, mCnt, kPrune, evalLen, part, gap;
      bit accepted, aborted, stop, curLast;
      logic [23:0] cur;
      pif.perm_valid = 1'b0;
      pif.perm_data  = '0;
      pif.perm_last  = 1'b0;
      forever begin
        @(goEv);
        mMin = 1023; mCnt = 0; idx = 0; aborted = 0; stop = 0;
        while (idx < sN && !stop) begin
          if (!pif.perm_valid) begin
            gap = (abortIdx >= 0) ? 0 : int'($urandom_range(0, 2));
            repeat (gap) begin @(posedge CLK); #1; end
            pif.perm_valid = 1'b1;
            pif.perm_data  = sPerm[idx];
            pif.perm_last  = sLast[idx];
          end
          guard = 0; accepted = 0;
          while (!accepted && guard < 64) begin
            @(posedge CLK);
            accepted = pif.perm_valid && pif.perm_ready;
            #1;
            guard++;
          end
          if (!accepted) begin
            checkVal("accept_timeout", 0, 1);
            stop = 1;
          end else begin
            cur = sPerm[idx]; curLast = sLast[idx];
            // Reference: total cost and the first worker whose partial sum beats the minimum.
            kPrune = -1; part = 0;
            for (int i = 0; i < 8; i++) begin
              part += int'(costTab[i][jobOf(cur, i)]);
              if (g == 0 && kPrune < 0 && part > mMin) kPrune = i;
            end
            evalLen = (kPrune >= 0) ? kPrune + 1 : 8;
            idx++;
            if (idx < sN && (abortIdx >= 0 || $urandom_range(0, 1) == 1)) begin
              pif.perm_data = sPerm[idx];
              pif.perm_last = sLast[idx];
            end else begin
              pif.perm_valid = 1'b0;
            end
            for (int c = 0; c < evalLen && !aborted; c++) begin
              if (idx - 1 == abortIdx && c == 4) begin
                aborted = 1;
                pif.perm_valid = 1'b0;
              end else begin
                checkVal("W", int'(W), c);
                checkVal("J", int'(J), jobOf(cur, c));
                checkVal("ready_busy", int'(pif.perm_ready), 0);
                @(posedge CLK); #1;
              end
            end
            if (aborted) begin
              stop = 1;
            end else begin
              if (kPrune < 0) begin
                checkVal("ready_cmp", int'(pif.perm_ready), 0);
                @(posedge CLK); #1;
                if (part < mMin) begin mMin = part; mCnt = 1; end
                else if (part == mMin && mCnt < 15) mCnt++;
              end
              checkVal("ready_after", int'(pif.perm_ready), curLast ? 0 : 1);
              checkVal("valid", int'(Valid), curLast ? 1 : 0);
              checkVal("min_cost", int'(MinCost), mMin);
              checkVal("match_cnt", int'(MatchCount), mCnt);
              checkVal("W_idle", int'(W), 0);
            end
          end
        end
        if (!stop) begin
          repeat (6) begin
            pif.perm_valid = 1'($urandom_range(0, 1));
            pif.perm_data  = 24'($urandom);
            pif.perm_last  = 1'($urandom_range(0, 1));
            @(posedge CLK); #1;
            checkVal("done_valid", int'(Valid), 1);
            checkVal("done_ready", int'(pif.perm_ready), 0);
            checkVal("done_min", int'(MinCost), mMin);
            checkVal("done_cnt", int'(MatchCount), mCnt);
          end
          pif.perm_valid = 1'b0;
        end
        doneFlag[g] = 1;
        ->doneEv;
      end
    end
  end

  task automatic checkReset();
    checkVal("rst_ready0", int'(lane[0].pif.perm_ready), 1);
    checkVal("rst_min0",   int'(lane[0].MinCost), 1023);
    checkVal("rst_cnt0",   int'(lane[0].MatchCount), 0);
    checkVal("rst_valid0", int'(lane[0].Valid), 0);
    checkVal("rst_W0",     int'(lane[0].W), 0);
    checkVal("rst_J0",     int'(lane[0].J), 0);
    checkVal("rst_ready1", int'(lane[1].pif.perm_ready), 1);
    checkVal("rst_min1",   int'(lane[1].MinCost), 1023);
    checkVal("rst_cnt1",   int'(lane[1].MatchCount), 0);
    checkVal("rst_valid1", int'(lane[1].Valid), 0);
    checkVal("rst_W1",     int'(lane[1].W), 0);
    checkVal("rst_J1",     int'(lane[1].J), 0);
  endtask

  task automatic setCostConst(int v);
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) costTab[i][j] = 7'(v);
  endtask

  task automatic fillRandom(int n);
    sN = n;
    for (int i = 0; i < n; i++) begin
      sPerm[i] = randPerm();
      sLast[i] = (i == n - 1);
    end
  endtask

  task automatic runScen(int abortAt);
    abortIdx = abortAt;
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    doneFlag[0] = 0;
    doneFlag[1] = 0;
    ->goEv;
    for (int t = 0; t < 4000 && !(doneFlag[0] && doneFlag[1]); t++)
      @(posedge CLK or doneEv);
    if (!(doneFlag[0] && doneFlag[1])) checkVal("scen_timeout", 0, 1);
  endtask

  initial begin
    int maxC;
    nVec = 0;
    nErr = 0;
    abortIdx = -1;
    sN = 0;
    RST = 1'b1;
    setCostConst(0);
    repeat (3) @(posedge CLK);
    #1;
    checkReset();
    RST = 1'b0;

    // Single identity permutation, flat cost 10.
    setCostConst(10);
    sN = 1; sPerm[0] = rotPerm(0); sLast[0] = 1;
    runScen(-1);

    // Three permutations, flat cost 5: every one ties.
    setCostConst(5);
    fillRandom(3);
    runScen(-1);

    // A totals 100; B starts with 120 at worker 0.
    setCostConst(20);
    for (int i = 0; i < 7; i++) costTab[i][i] = 7'd12;
    costTab[7][7] = 7'd16;
    costTab[0][1] = 7'd120;
    sN = 2;
    sPerm[0] = rotPerm(0); sLast[0] = 0;
    sPerm[1] = rotPerm(1); sLast[1] = 1;
    runScen(-1);

    // Twenty ties at 64: match count saturates.
    setCostConst(8);
    fillRandom(20);
    runScen(-1);

    // Reset while the second permutation is at worker 4.
    setCostConst(5);
    fillRandom(2);
    runScen(1);
    checkVal("pre_rst_W0", int'(lane[0].W), 4);
    checkVal("pre_rst_W1", int'(lane[1].W), 4);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    checkReset();
    RST = 1'b0;

    // Random cost tables and permutation lists.
    for (int s = 0; s < 10; s++) begin
      case (s % 3)
        0:       maxC = 3;
        1:       maxC = 20;
        default: maxC = 127;
      endcase
      for (int i = 0; i < 8; i++)
        for (int j = 0; j < 8; j++) costTab[i][j] = 7'($urandom_range(0, maxC));
      fillRandom(int'($urandom_range(2, 9)));
      if (s % 2 == 1) sPerm[sN - 1] = sPerm[0];
      runScen(-1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end
endmodule

// File: doc/jam_cost_sched.md
Name: jam_cost_sched

Overview:
- Sequencer for the job-assignment cost datapath.
- Accepts complete worker→job permutations from the permutation generator over a valid/ready handshake.
- For each accepted permutation, walks the 8 workers through the shared cost-ROM address port (W/J) and accumulates the total cost.
- Maintains the running minimum total and the count of permutations that achieve it, then raises Valid after the permutation flagged last has been resolved.

Parameters:
- PRUNE_EN, 1, 1 = abort a permutation as soon as its partial sum strictly exceeds the current minimum; 0 = always evaluate all 8 workers.
- MIN_INIT, 1023, reset/initial value of MinCost (10-bit).

Ports:
- CLK  in  1  clock, all logic on the rising edge.
- RST  in  1  synchronous, active-high reset.
- perm_valid  in  1  generator holds a permutation on perm_data.
- perm_ready  out  1  scheduler can accept a permutation.
- perm_data  in  24  job for worker i at bits [3i+2:3i], i = 0..7.
- perm_last  in  1  qualifies perm_data as the final permutation.
- W  out  3  cost-ROM worker index.
- J  out  3  cost-ROM job index.
- Cost  in  7  cost-ROM data for the current W/J, valid in the same cycle (combinational ROM), sampled on the next rising edge.
- MinCost  out  10  minimum total cost found so far.
- MatchCount  out  4  number of permutations achieving MinCost, saturating at 15.
- Valid  out  1  results final.

Behaviour:
- Reset (synchronous, active-high RST on CLK edge) values:
  - state = IDLE; perm_ready = 1; W = 0; J = 0; MinCost = MIN_INIT; MatchCount = 0; Valid = 0.
  - Internal acc = 0, widx = 0, last_r = 0.
  - RST asserted in any state, including mid-EVAL, discards the in-flight permutation and all results.
- States: IDLE, EVAL, CMP, DONE.
- IDLE:
  - perm_ready = 1.
  - On perm_valid & perm_ready: latch perm_data → perm_r and perm_last → last_r; set acc = 0, widx = 0; go to EVAL.
  - Otherwise stay in IDLE.
- EVAL:
  - perm_ready = 0; W = widx; J = perm_r[widx].
  - Each cycle: acc_next = acc + Cost (10-bit, cannot overflow: 8×127 = 1016); acc ← acc_next.
  - Prune: if PRUNE_EN and acc_next > MinCost (strict), go to IDLE, or to DONE if last_r. MinCost and MatchCount are unchanged.
  - Else if widx == 7, go to CMP.
  - Else widx ← widx + 1.
  - Pruning takes priority over widx == 7 in the same cycle.
- CMP (1 cycle, uses the final acc):
  - acc < MinCost: MinCost ← acc, MatchCount ← 1.
  - acc == MinCost: MatchCount ← min(MatchCount + 1, 15).
  - acc > MinCost: no change.
  - Next state: DONE if last_r, else IDLE.
- DONE:
  - Valid = 1; perm_ready = 0; perm_valid is ignored.
  - Outputs hold until RST.
- W/J outside EVAL = 0.
- Latency and throughput:
  - Full evaluation: 1 accept cycle + 8 EVAL + 1 CMP = 10 cycles per permutation.
  - A permutation pruned at worker k (0-based) occupies 1 + (k + 1) cycles.
  - Valid rises on the cycle after CMP (or after the prune cycle) of the last permutation.
- Handshake:
  - The generator must hold perm_data and perm_last stable while perm_valid is high and perm_ready is low.
  - The scheduler never drops a presented permutation.
  - perm_valid low in IDLE: scheduler waits indefinitely with no state change.
- Equal-to-minimum partial sums are never pruned, so ties are always counted.
- With MIN_INIT = 1023, the first permutation always sets MinCost and sets MatchCount = 1.

Test Plan:
- Single permutation 0..7 with perm_last = 1, Cost ≡ 10 for every W/J → W steps 0..7 on consecutive cycles; J = perm_data entries; 10 cycles after accept MinCost = 80, MatchCount = 1, Valid = 1.
- Three permutations, all costs ≡ 5, last on the third → MinCost = 40, MatchCount = 3; with PRUNE_EN = 1 no permutation is pruned (equality).
- Perm A total 100, perm B with cost 120 at worker 0 (PRUNE_EN = 1) → B returns to IDLE after 2 cycles (accept + one EVAL cycle); MinCost stays 100, MatchCount stays 1. Same stimulus with PRUNE_EN = 0 → B takes 10 cycles with identical results.
- 20 permutations with identical totals of 64 → MatchCount saturates at 15; MinCost = 64.
- RST asserted at widx = 4 of the second permutation → next cycle: IDLE, perm_ready = 1, MinCost = 1023, MatchCount = 0, Valid = 0; a following full run gives correct results.
- perm_valid asserted while in EVAL, then held with changing-free data → accepted only on return to IDLE; no extra or lost evaluation; after DONE further perm_valid pulses leave all outputs unchanged.
